// File: rtl/encoder_1hot_8to3_serial.sv
// Serialising 8-to-3 one-hot encoder: turns an accepted 8-bit vector into one
// binary index per set bit, lowest first, with valid/ready on both sides.
module encoder_1hot_8to3_serial #(
    parameter bit ERR_ON_MULTI = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] f,
    output logic       f_valid,
    input  logic       f_ready,
    output logic       f_last,
    output logic       err,
    output logic       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; a producer holds its payload stable while valid && !ready.

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [2:0] f_q, f_d;
    logic       f_valid_q, f_valid_d;
    logic       f_last_q, f_last_d;
    logic       err_q, err_d;

    logic [7:0] remaining;
    logic       in_zero;
    logic       in_multi;

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                lowest_idx = i[2:0];
            end
        end
    endfunction

    function automatic logic [3:0] popcount(input logic [7:0] v);
        popcount = 4'd0;
        for (int i = 0; i < 8; i++) begin
            popcount = popcount + {3'd0, v[i]};
        end
    endfunction

    assign remaining = pending_q & ~(8'h01 << f_q);
    assign in_zero   = (in == 8'h00);
    assign in_multi  = (popcount(in) > 4'd1);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        f_d       = f_q;
        f_valid_d = f_valid_q;
        f_last_d  = f_last_q;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_zero || (ERR_ON_MULTI && in_multi)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = EMIT;
                        pending_d = in;
                        f_d       = lowest_idx(in);
                        f_valid_d = 1'b1;
                        f_last_d  = !in_multi;
                    end
                end
            end
            EMIT: begin
                if (f_ready) begin
                    if (f_last_q) begin
                        state_d   = IDLE;
                        pending_d = 8'h00;
                        f_d       = 3'd0;
                        f_valid_d = 1'b0;
                        f_last_d  = 1'b0;
                    end else begin
                        // Present the next-lowest bit straight from the cleared mask.
                        pending_d = remaining;
                        f_d       = lowest_idx(remaining);
                        f_last_d  = (popcount(remaining) == 4'd1);
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 8'h00;
                f_d       = 3'd0;
                f_valid_d = 1'b0;
                f_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 8'h00;
            f_q       <= 3'd0;
            f_valid_q <= 1'b0;
            f_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
            f_last_q  <= f_last_d;
            err_q     <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign f         = f_q;
    assign f_valid   = f_valid_q;
    assign f_last    = f_last_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
